onewire_master: RTL and testbench
=================================

ONEWIRE_MASTER -- requirements
Module: onewire_master

Interface
REQ-001 The block SHALL have parameter CLK_MHZ, default 50, meaning system clock frequency in MHz, used to derive a 1 us tick.
REQ-002 The block SHALL have port clk, input, 1, system clock, rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, command request.
REQ-005 The block SHALL have port cmd_ready, output, 1, block idle and able to accept a command.
REQ-006 The block SHALL have port cmd, input, 2, command code: 0 = bus reset, 1 = write byte, 2 = read byte, 3 = NOP.
REQ-007 The block SHALL have port wr_data, input, 8, byte to write, captured on acceptance.
REQ-008 The block SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have port rd_data, output, 8, last byte read, stable until the next read completes.
REQ-010 The block SHALL have port presence, output, 1, presence detected in the last bus reset.
REQ-011 The block SHALL have port dq, inout, 1, open-drain 1-Wire line: driven 0 or released to z, never driven 1.

Function
REQ-012 A command SHALL be accepted in the cycle where cmd_valid and cmd_ready are both 1; cmd_ready SHALL drop the next cycle and stay 0 until the rsp_valid cycle.
REQ-013 A free-running prescaler SHALL emit a 1-cycle tick every CLK_MHZ clocks; all bus timing SHALL count ticks, with counters restarted on each state entry.
REQ-014 States: IDLE, RST_LOW, RST_WAIT, RST_REC, SLOT_LOW, SLOT_WAIT, SLOT_REC, DONE.
REQ-015 Bus reset: RST_LOW drives dq low 480 us; RST_WAIT releases for 70 us then samples dq; presence = 1 when sampled 0; RST_REC waits a further 410 us; then DONE.
REQ-016 Write byte: 8 slots, LSB first; bit 1 = low 6 us then released 64 us; bit 0 = low 60 us then released 10 us.
REQ-017 Read byte: 8 slots, LSB first; low 6 us, release, sample dq 9 us after release, recover 55 us; sampled bit shifts into bit 7 of a shift register, copied to rd_data at DONE.
REQ-018 Each slot SHALL be followed by at least 1 us released before the next slot begins (included in SLOT_REC).
REQ-019 DONE SHALL last exactly one cycle, assert rsp_valid, and return to IDLE with cmd_ready = 1 the following cycle.
REQ-020 NOP SHALL produce rsp_valid one cycle after acceptance with no bus activity; presence and rd_data unchanged.
REQ-021 cmd_valid while cmd_ready = 0 SHALL be ignored; cmd and wr_data changes after acceptance SHALL have no effect.
REQ-022 dq SHALL be sampled through a 2-flop synchronizer; sample points account for its latency (at most 2 clocks).

Reset
REQ-023 While rst_n = 0: dq released immediately, state IDLE, cmd_ready 1, rsp_valid 0, rd_data 0x00, presence 0, prescaler and counters 0.
REQ-024 Reset mid-transaction SHALL abort without completing the slot and without rsp_valid; first command after release starts cleanly.

Configuration
REQ-025 With ONEWIRE_CRC8_EN defined, the block SHALL add output crc_ok (1 bit) and maintain Dallas CRC-8 (x^8+x^5+x^4+1, LSB-first) over every read bit; CRC cleared by each bus reset; crc_ok = 1 when CRC register is 0x00, reset value 0.
REQ-026 Without ONEWIRE_CRC8_EN, no CRC logic or crc_ok port SHALL exist; all other behaviour identical.

Structure
REQ-027 Package onewire_pkg SHALL hold the command enum, state enum and timing constants (480, 70, 410, 6, 60, 64, 10, 9, 55 us).
REQ-028 CRC update SHALL be a sub-module onewire_crc8 (bit-serial, enable, clear), instantiated only under ONEWIRE_CRC8_EN.

Verification
REQ-029 Bus reset with DS18B20 model attached -> dq low 480 us +/- 1 us, presence = 1, rsp_valid ~960 us after acceptance; no model -> presence = 0.
REQ-030 Write 0xCC -> slot pattern LSB first 0,0,1,1,0,0,1,1: low durations 60,60,6,6,60,60,6,6 us; one rsp_valid.
REQ-031 Read with model returning 0x50 -> rd_data = 0x50 at rsp_valid; cmd_ready 0 for whole transaction.
REQ-032 cmd_valid pulsed with cmd = 1 while busy -> ignored, no extra slots, exactly one rsp_valid.
REQ-033 rst_n low at 3rd write slot low phase -> dq released within the same cycle, no rsp_valid; subsequent NOP -> rsp_valid one cycle after acceptance.
REQ-034 ONEWIRE_CRC8_EN: bus reset, read 9 scratchpad bytes with valid CRC from model -> crc_ok = 1; corrupt one byte -> crc_ok = 0.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire bus master: command codes, FSM states
// and the bus timing constants, all expressed in microseconds.
package onewire_pkg;

   typedef enum logic [1:0] {
      CMD_RESET = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2,
      CMD_NOP   = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RST_LOW   = 3'd1,
      ST_RST_WAIT  = 3'd2,
      ST_RST_REC   = 3'd3,
      ST_SLOT_LOW  = 3'd4,
      ST_SLOT_WAIT = 3'd5,
      ST_SLOT_REC  = 3'd6,
      ST_DONE      = 3'd7
   } state_t;

   // Longest interval is 480 us, so 9 bits of microsecond count suffice.
   localparam int TIMER_W = 9;

   localparam logic [TIMER_W-1:0] T_RST_LOW_US   = TIMER_W'(480);
   localparam logic [TIMER_W-1:0] T_RST_WAIT_US  = TIMER_W'(70);
   localparam logic [TIMER_W-1:0] T_RST_REC_US   = TIMER_W'(410);
   localparam logic [TIMER_W-1:0] T_SLOT_LOW_US  = TIMER_W'(6);
   localparam logic [TIMER_W-1:0] T_W0_LOW_US    = TIMER_W'(60);
   localparam logic [TIMER_W-1:0] T_W1_REL_US    = TIMER_W'(64);
   localparam logic [TIMER_W-1:0] T_W0_REL_US    = TIMER_W'(10);
   localparam logic [TIMER_W-1:0] T_RD_SAMPLE_US = TIMER_W'(9);
   localparam logic [TIMER_W-1:0] T_RD_REC_US    = TIMER_W'(55);
   // Minimum released gap between consecutive slots; it is carved out of
   // the write release time so every slot stays 70 us long.
   localparam logic [TIMER_W-1:0] T_SLOT_GAP_US  = TIMER_W'(1);

   // How many microsecond ticks the given state lasts. States that are not
   // timed (IDLE, DONE) return 1; their timer result is never consulted.
   function automatic logic [TIMER_W-1:0] stateDurUs(
      input state_t st,
      input logic   isRead,
      input logic   txBit
   );
      logic [TIMER_W-1:0] dur;
      dur = TIMER_W'(1);
      case (st)
         ST_RST_LOW:   dur = T_RST_LOW_US;
         ST_RST_WAIT:  dur = T_RST_WAIT_US;
         ST_RST_REC:   dur = T_RST_REC_US;
         ST_SLOT_LOW:  dur = (isRead || txBit) ? T_SLOT_LOW_US : T_W0_LOW_US;
         ST_SLOT_WAIT: dur = isRead ? T_RD_SAMPLE_US :
                             (txBit ? (T_W1_REL_US - T_SLOT_GAP_US)
                                    : (T_W0_REL_US - T_SLOT_GAP_US));
         ST_SLOT_REC:  dur = isRead ? T_RD_REC_US : T_SLOT_GAP_US;
         default:      dur = TIMER_W'(1);
      endcase
      return dur;
   endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Bit-serial Dallas/Maxim CRC-8 (x^8 + x^5 + x^4 + 1, LSB first) for the
// 1-Wire master. Only exists when ONEWIRE_CRC8_EN is defined.
`ifdef ONEWIRE_CRC8_EN
module onewire_crc8 (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   input  logic bit_i,
   output logic ok_o
);

   logic [7:0] crc_q;
   logic       primed_q;
   logic       feedback;

   assign feedback = crc_q[0] ^ bit_i;

   // Shift one received bit into the CRC; a clear wins over an update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q    <= 8'h00;
         primed_q <= 1'b0;
      end else if (clr_i) begin
         crc_q    <= 8'h00;
         primed_q <= 1'b1;
      end else if (en_i) begin
         crc_q    <= {1'b0, crc_q[7:1]} ^ (feedback ? 8'h8C : 8'h00);
         primed_q <= 1'b1;
      end
   end

   // The register is zero out of reset, so only report a good CRC once it
   // has actually been cleared by a bus reset or fed with data.
   assign ok_o = primed_q && (crc_q == 8'h00);

endmodule
`endif

// File: rtl/onewire_master.sv
// 1-Wire bus master: bus reset with presence detect, byte write and byte
// read, all timed from a 1 us tick derived from CLK_MHZ.
// Optional feature: define ONEWIRE_CRC8_EN to add the crc_ok output.
module onewire_master #(
   parameter int CLK_MHZ = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wr_data,
   output logic       rsp_valid,
   output logic [7:0] rd_data,
   output logic       presence,
`ifdef ONEWIRE_CRC8_EN
   output logic       crc_ok,
`endif
   inout  wire        dq
);

   import onewire_pkg::*;

   localparam int PRESC_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_MHZ - 1);

   logic [PRESC_W-1:0] presc_q;
   logic               usTick;

   logic               dqMeta_q;
   logic               dqSync_q;

   state_t             state_q;
   state_t             state_d;
   logic [TIMER_W-1:0] usCnt_q;
   logic [TIMER_W-1:0] curDur;
   logic               stateDone;

   cmd_t               cmd_q;
   logic [7:0]         txByte_q;
   logic [7:0]         rxShift_q;
   logic [7:0]         rdData_q;
   logic               presence_q;
   logic [2:0]         bitCnt_q;

   logic               cmdAccept;
   logic               isRead;
   logic               txBit;
   logic               readSample;
   logic               driveLow;
   logic               cmdReady;
   logic               rspValid;

   // Free-running prescaler producing a single-cycle tick every microsecond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (presc_q == PRESC_MAX) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign usTick = (presc_q == PRESC_MAX);

   // Two-flop synchronizer on the bus; idles high like the pulled-up line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dqMeta_q <= 1'b1;
         dqSync_q <= 1'b1;
      end else begin
         dqMeta_q <= dq;
         dqSync_q <= dqMeta_q;
      end
   end

   assign cmdAccept  = cmd_valid && (state_q == ST_IDLE);
   assign isRead     = (cmd_q == CMD_READ);
   assign txBit      = txByte_q[bitCnt_q];
   assign curDur     = stateDurUs(state_q, isRead, txBit);
   assign stateDone  = usTick && (usCnt_q == (curDur - TIMER_W'(1)));
   // The synchronized value lags the pin by two clocks, well inside the
   // margin the slave keeps its bit on the line.
   assign readSample = (state_q == ST_SLOT_WAIT) && stateDone && isRead;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic: each timed state leaves on its last microsecond.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_t'(cmd))
                  CMD_RESET: state_d = ST_RST_LOW;
                  CMD_WRITE: state_d = ST_SLOT_LOW;
                  CMD_READ:  state_d = ST_SLOT_LOW;
                  default:   state_d = ST_DONE;
               endcase
            end
         end
         ST_RST_LOW:   if (stateDone) state_d = ST_RST_WAIT;
         ST_RST_WAIT:  if (stateDone) state_d = ST_RST_REC;
         ST_RST_REC:   if (stateDone) state_d = ST_DONE;
         ST_SLOT_LOW:  if (stateDone) state_d = ST_SLOT_WAIT;
         ST_SLOT_WAIT: if (stateDone) state_d = ST_SLOT_REC;
         ST_SLOT_REC: begin
            if (stateDone) begin
               state_d = (bitCnt_q == 3'd7) ? ST_DONE : ST_SLOT_LOW;
            end
         end
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: which states pull the line low, handshake and completion.
   always_comb begin
      driveLow = 1'b0;
      cmdReady = 1'b0;
      rspValid = 1'b0;
      case (state_q)
         ST_RST_LOW,
         ST_SLOT_LOW: driveLow = 1'b1;
         ST_IDLE:     cmdReady = 1'b1;
         ST_DONE:     rspValid = 1'b1;
         default:     ;
      endcase
   end

   // Microsecond counter, restarted on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         usCnt_q <= '0;
      end else if (state_d != state_q) begin
         usCnt_q <= '0;
      end else if (usTick) begin
         usCnt_q <= usCnt_q + 1'b1;
      end
   end

   // Command capture, bit sequencing, presence and received-byte tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q      <= CMD_NOP;
         txByte_q   <= 8'h00;
         rxShift_q  <= 8'h00;
         rdData_q   <= 8'h00;
         presence_q <= 1'b0;
         bitCnt_q   <= 3'd0;
      end else begin
         if (cmdAccept) begin
            cmd_q    <= cmd_t'(cmd);
            txByte_q <= wr_data;
            bitCnt_q <= 3'd0;
         end
         if ((state_q == ST_RST_WAIT) && stateDone) begin
            presence_q <= ~dqSync_q;
         end
         if (readSample) begin
            rxShift_q <= {dqSync_q, rxShift_q[7:1]};
         end
         if ((state_q == ST_SLOT_REC) && stateDone) begin
            bitCnt_q <= bitCnt_q + 3'd1;
         end
         if ((state_q == ST_DONE) && isRead) begin
            rdData_q <= rxShift_q;
         end
      end
   end

   assign dq        = driveLow ? 1'b0 : 1'bz;
   assign cmd_ready = cmdReady;
   assign rsp_valid = rspValid;
   assign rd_data   = rdData_q;
   assign presence  = presence_q;

`ifdef ONEWIRE_CRC8_EN
   logic crcClr;

   assign crcClr = cmdAccept && (cmd_t'(cmd) == CMD_RESET);

   onewire_crc8 u_crc8 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (crcClr),
      .en_i  (readSample),
      .bit_i (dqSync_q),
      .ok_o  (crc_ok)
   );
`endif

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master with a behavioural 1-Wire slave
// on the bus. Build with ONEWIRE_CRC8_EN defined to also cover crc_ok.
module tb_onewire_master;

   localparam int CLK_MHZ = 2;
   localparam int U       = CLK_MHZ;
   localparam int LIMIT   = 1200 * U;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd;
   logic [7:0] wr_data;
   logic       rsp_valid;
   logic [7:0] rd_data;
   logic       presence;
`ifdef ONEWIRE_CRC8_EN
   logic       crc_ok;
`endif
   wire        dq;

   logic       slaveLow;
   logic       presenceEn;
   bit         readQ[$];
   int         lowLog[$];
   int         resetLog[$];

   int         testsRun;
   int         testsFailed;

   logic [7:0] modelRd;
   logic       modelPresence;

   typedef struct {
      logic [1:0] cmd;
      logic [7:0] data;
      logic [7:0] slaveByte;
      logic       present;
      bit         poke;
      logic [7:0] expRd;
      logic       expPresence;
   } vec_t;

   vec_t vecs[8];

   pullup (dq);
   assign dq = slaveLow ? 1'b0 : 1'bz;

   onewire_master #(.CLK_MHZ(CLK_MHZ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .wr_data   (wr_data),
      .rsp_valid (rsp_valid),
      .rd_data   (rd_data),
      .presence  (presence),
`ifdef ONEWIRE_CRC8_EN
      .crc_ok    (crc_ok),
`endif
      .dq        (dq)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural slave: answers bus resets with a presence pulse, holds the
   // line low for queued read zeros, and logs master low-pulse lengths.
   initial begin : slaveModel
      int lowCycles;
      bit sb;
      slaveLow = 1'b0;
      forever begin
         @(negedge clk);
         if (dq === 1'b0 && !slaveLow) begin
            if (readQ.size() > 0) begin
               sb = readQ.pop_front();
               if (!sb) begin
                  slaveLow = 1'b1;
                  repeat (30 * U) @(negedge clk);
                  slaveLow = 1'b0;
               end else begin
                  while (dq === 1'b0) @(negedge clk);
               end
            end else begin
               lowCycles = 1;
               while (1) begin
                  @(negedge clk);
                  if (dq !== 1'b0) break;
                  lowCycles++;
               end
               if (lowCycles >= 400 * U) begin
                  resetLog.push_back(lowCycles);
                  if (presenceEn) begin
                     repeat (20 * U) @(negedge clk);
                     slaveLow = 1'b1;
                     repeat (120 * U) @(negedge clk);
                     slaveLow = 1'b0;
                  end
               end else begin
                  lowLog.push_back(lowCycles);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual,
                             input int lo, input int hi);
      testsRun++;
      if (actual < lo || actual > hi) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   // Issue one command, follow it to completion and compare everything the
   // spec fixes: latency, handshake, bus low pulses, rd_data and presence.
   task automatic applyStimulus(input logic [1:0] c, input logic [7:0] d,
                                input logic [7:0] sByte, input logic present,
                                input bit poke, input logic [7:0] expRd,
                                input logic expPres);
      int  lat;
      int  extraRsp;
      bit  readyBad;
      bit  busBad;
      int  expUs;
      int  states;
      int  n;
      presenceEn = present;
      readQ.delete();
      lowLog.delete();
      resetLog.delete();
      if (c == 2'd2) begin
         for (int i = 0; i < 8; i++) readQ.push_back(sByte[i]);
      end
      @(negedge clk);
      checkOutput("readyBeforeCmd", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd       = c;
      wr_data   = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 2'($urandom);
      wr_data   = 8'($urandom);
      lat       = 1;
      readyBad  = 1'b0;
      while (!rsp_valid && lat < LIMIT) begin
         if (cmd_ready) readyBad = 1'b1;
         if (poke && lat == 40) begin
            cmd_valid = 1'b1;
            cmd       = 2'd1;
            wr_data   = 8'hFF;
         end else if (poke && lat == 41) begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      cmd_valid = 1'b0;
      checkOutput("rspSeen", rsp_valid, 1);
      if (cmd_ready) readyBad = 1'b1;
      checkOutput("readyLowWhileBusy", readyBad, 0);
      case (c)
         2'd0:    begin expUs = 960; states = 3;  end
         2'd3:    begin expUs = 0;   states = 0;  end
         default: begin expUs = 560; states = 24; end
      endcase
      if (c == 2'd3) checkOutput("nopLatency", lat, 1);
      else checkRange("rspLatency", lat, expUs * U - states * (U - 1) + 1, expUs * U + 1);
      @(negedge clk);
      checkOutput("readyAfterDone", cmd_ready, 1);
      extraRsp = rsp_valid ? 1 : 0;
      busBad   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) extraRsp++;
         if (dq !== 1'b1) busBad = 1'b1;
      end
      checkOutput("singleRsp", extraRsp, 0);
      checkOutput("busIdleAfter", busBad, 0);
      checkOutput("rdData", rd_data, expRd);
      checkOutput("presence", presence, expPres);
      if (c == 2'd1) begin
         checkOutput("writeSlotCount", lowLog.size(), 8);
         n = (lowLog.size() < 8) ? lowLog.size() : 8;
         for (int i = 0; i < n; i++) begin
            expUs = d[i] ? 6 : 60;
            checkRange($sformatf("writeLow%0d", i), lowLog[i], expUs * U - U, expUs * U + U);
         end
      end else begin
         checkOutput("noWriteSlots", lowLog.size(), 0);
      end
      if (c == 2'd0) begin
         checkOutput("resetPulseCount", resetLog.size(), 1);
         if (resetLog.size() > 0) checkRange("resetLow", resetLog[0], 479 * U, 481 * U);
      end else begin
         checkOutput("noResetPulse", resetLog.size(), 0);
      end
   endtask

   // Reference model: what each command leaves behind.
   task automatic modelUpdate(input logic [1:0] c, input logic [7:0] sByte,
                              input logic present);
      if (c == 2'd0) modelPresence = present;
      if (c == 2'd2) modelRd = sByte;
   endtask

`ifdef ONEWIRE_CRC8_EN
   function automatic logic [7:0] dallasCrc(input logic [7:0] bytes[8]);
      logic [7:0] crc;
      logic       fb;
      crc = 8'h00;
      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < 8; b++) begin
            fb  = crc[0] ^ bytes[i][b];
            crc = crc >> 1;
            if (fb) crc = crc ^ 8'h8C;
         end
      end
      return crc;
   endfunction
`endif

   initial begin : mainTest
      int   falls;
      bit   prevHigh;
      int   cyc;
      bit   rspDuringReset;
      bit   busBad;
      logic [1:0] rc;
      logic [7:0] rd8;
      logic [7:0] rs8;
      logic       rp;
`ifdef ONEWIRE_CRC8_EN
      logic [7:0] pad[8];
      logic [7:0] padCrc;
`endif
      testsRun      = 0;
      testsFailed   = 0;
      presenceEn    = 1'b0;
      cmd_valid     = 1'b0;
      cmd           = 2'd3;
      wr_data       = 8'h00;
      modelRd       = 8'h00;
      modelPresence = 1'b0;

      vecs[0] = '{2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[1] = '{2'd1, 8'hCC, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{2'd2, 8'h00, 8'h50, 1'b1, 1'b0, 8'h50, 1'b1};
      vecs[3] = '{2'd1, 8'h3C, 8'h00, 1'b1, 1'b1, 8'h50, 1'b1};
      vecs[4] = '{2'd3, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h50, 1'b1};
      vecs[5] = '{2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h50, 1'b0};
      vecs[6] = '{2'd2, 8'h00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
      vecs[7] = '{2'd3, 8'h12, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetReady", cmd_ready, 1);
      checkOutput("resetRsp", rsp_valid, 0);
      checkOutput("resetRdData", rd_data, 8'h00);
      checkOutput("resetPresence", presence, 0);
      checkOutput("resetDqReleased", dq === 1'b1, 1);
`ifdef ONEWIRE_CRC8_EN
      checkOutput("resetCrcOk", crc_ok, 0);
`endif
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         modelUpdate(vecs[i].cmd, vecs[i].slaveByte, vecs[i].present);
         applyStimulus(vecs[i].cmd, vecs[i].data, vecs[i].slaveByte, vecs[i].present,
                       vecs[i].poke, vecs[i].expRd, vecs[i].expPresence);
      end

      // Abort a write during the low phase of its third slot.
      presenceEn = 1'b0;
      readQ.delete();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd       = 2'd1;
      wr_data   = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b0;
      falls     = 0;
      prevHigh  = 1'b1;
      cyc       = 0;
      while (falls < 3 && cyc < 800 * U) begin
         if (prevHigh && dq === 1'b0) falls++;
         prevHigh = (dq !== 1'b0);
         if (falls < 3) begin
            @(negedge clk);
            cyc++;
         end
      end
      checkOutput("thirdSlotSeen", falls, 3);
      repeat (10 * U) @(negedge clk);
      checkOutput("dqLowInThirdSlot", dq === 1'b0, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("dqReleasedOnReset", dq === 1'b1, 1);
      checkOutput("readyInReset", cmd_ready, 1);
      rspDuringReset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid) rspDuringReset = 1'b1;
      end
      checkOutput("noRspInReset", rspDuringReset, 0);
      checkOutput("rdDataClearedByReset", rd_data, 8'h00);
      checkOutput("presenceClearedByReset", presence, 0);
      modelRd       = 8'h00;
      modelPresence = 1'b0;
      rst_n = 1'b1;
      busBad = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (rsp_valid || dq !== 1'b1 || !cmd_ready) busBad = 1'b1;
      end
      checkOutput("quietAfterAbort", busBad, 0);
      applyStimulus(2'd3, 8'h00, 8'h00, 1'b0, 1'b0, modelRd, modelPresence);
      applyStimulus(2'd1, 8'h96, 8'h00, 1'b0, 1'b0, modelRd, modelPresence);

      // Randomized commands checked against the reference model.
      for (int i = 0; i < 8; i++) begin
         rc  = 2'($urandom_range(3, 0));
         rd8 = 8'($urandom);
         rs8 = 8'($urandom);
         rp  = 1'($urandom);
         modelUpdate(rc, rs8, rp);
         applyStimulus(rc, rd8, rs8, rp, 1'($urandom), modelRd, modelPresence);
      end

`ifdef ONEWIRE_CRC8_EN
      for (int i = 0; i < 8; i++) pad[i] = 8'($urandom);
      padCrc = dallasCrc(pad);
      modelUpdate(2'd0, 8'h00, 1'b1);
      applyStimulus(2'd0, 8'h00, 8'h00, 1'b1, 1'b0, modelRd, modelPresence);
      for (int i = 0; i < 9; i++) begin
         rs8 = (i < 8) ? pad[i] : padCrc;
         modelUpdate(2'd2, rs8, 1'b1);
         applyStimulus(2'd2, 8'h00, rs8, 1'b1, 1'b0, modelRd, modelPresence);
      end
      checkOutput("crcOkGood", crc_ok, 1);
      pad[3] = pad[3] ^ 8'h10;
      modelUpdate(2'd0, 8'h00, 1'b1);
      applyStimulus(2'd0, 8'h00, 8'h00, 1'b1, 1'b0, modelRd, modelPresence);
      for (int i = 0; i < 9; i++) begin
         rs8 = (i < 8) ? pad[i] : padCrc;
         modelUpdate(2'd2, rs8, 1'b1);
         applyStimulus(2'd2, 8'h00, rs8, 1'b1, 1'b0, modelRd, modelPresence);
      end
      checkOutput("crcOkCorrupt", crc_ok, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
